// File: rtl/pio_instr_mem.sv
// Instruction-side responder for one PIO state machine:
// program memory, loader, forced-instruction injector, clock divider.
module pio_instr_mem #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              rd,
    output logic [DATA_W-1:0] instr_data,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   load_len,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    input  logic              force_req,
    input  logic [DATA_W-1:0] force_instr,
    output logic              force_pending,
    output logic              flag_abnormal,
    output logic [DATA_W-1:0] jmp_data,
    input  logic              div_en,
    input  logic [DIV_W-1:0]  clkdiv_int,
    output logic              penable
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } ld_state_t;

    ld_state_t           state;
    ld_state_t           state_nxt;
    logic [ADDR_W-1:0]   waddr;
    logic [ADDR_W-1:0]   waddr_nxt;
    logic [ADDR_W:0]     remaining;
    logic [ADDR_W:0]     remaining_nxt;
    logic                accept;
    logic                len_ok;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DIV_W-1:0]    count;
    logic [DIV_W-1:0]    div_m1;
    logic                pen_tick;

    // Loader status is decoded straight from the state register.
    assign load_ready = (state == LOAD);
    assign load_busy  = (state != IDLE);
    assign load_done  = (state == DONE);
    assign accept     = load_valid && load_ready;
    assign len_ok     = (load_len != '0) && (load_len <= DEPTH_L);

    // A divider value of 0 wraps to all-ones, i.e. a period of 2**DIV_W.
    assign div_m1   = clkdiv_int - DIV_W'(1);
    assign pen_tick = div_en && (count >= div_m1);

    // Loader state, write pointer and word countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            waddr     <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            waddr     <= waddr_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Loader next-state: out-of-range lengths never leave IDLE.
    always_comb begin
        state_nxt     = state;
        waddr_nxt     = waddr;
        remaining_nxt = remaining;
        unique case (state)
            IDLE: begin
                if (load_start && len_ok) begin
                    state_nxt     = LOAD;
                    waddr_nxt     = load_addr;
                    remaining_nxt = load_len;
                end
            end
            LOAD: begin
                if (accept) begin
                    waddr_nxt     = waddr + ADDR_W'(1);
                    remaining_nxt = remaining - LEN_ONE;
                    if (remaining == LEN_ONE) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Program storage; reset fills it with JMP 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[waddr] <= load_data;
        end
    end

    // Registered fetch; a same-edge write to pc is forwarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_data <= '0;
        end else if (rd) begin
            if (accept && (waddr == pc)) begin
                instr_data <= load_data;
            end else begin
                instr_data <= mem[pc];
            end
        end
    end

    // Clock divider producing the state-machine tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            penable <= 1'b0;
        end else if (!div_en) begin
            count   <= '0;
            penable <= 1'b0;
        end else if (pen_tick) begin
            count   <= '0;
            penable <= 1'b1;
        end else begin
            count   <= count + DIV_W'(1);
            penable <= 1'b0;
        end
    end

    // Forced instruction: latest request wins, issued on a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jmp_data      <= '0;
            force_pending <= 1'b0;
            flag_abnormal <= 1'b0;
        end else begin
            flag_abnormal <= pen_tick && force_pending;
            if (force_req) begin
                jmp_data      <= force_instr;
                force_pending <= 1'b1;
            end else if (pen_tick) begin
                force_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pio_instr_mem.sv
// Bench for pio_instr_mem: directed tables and sequences,
// then random traffic against a behavioural model.
module tb_pio_instr_mem;

    logic        clk;
    logic        reset;
    logic [4:0]  pc;
    logic        rd;
    logic [15:0] instr_data;
    logic        load_start;
    logic [4:0]  load_addr;
    logic [5:0]  load_len;
    logic [15:0] load_data;
    logic        load_valid;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;
    logic        force_req;
    logic [15:0] force_instr;
    logic        force_pending;
    logic        flag_abnormal;
    logic [15:0] jmp_data;
    logic        div_en;
    logic [15:0] clkdiv_int;
    logic        penable;

    int checks;
    int errors;

    pio_instr_mem dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .rd            (rd),
        .instr_data    (instr_data),
        .load_start    (load_start),
        .load_addr     (load_addr),
        .load_len      (load_len),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .force_req     (force_req),
        .force_instr   (force_instr),
        .force_pending (force_pending),
        .flag_abnormal (flag_abnormal),
        .jmp_data      (jmp_data),
        .div_en        (div_en),
        .clkdiv_int    (clkdiv_int),
        .penable       (penable)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [15:0] div;
        int          ncyc;
    } div_vec_t;

    rd_vec_t  rv [6];
    div_vec_t dv [4];

    logic [15:0] mm [32];
    int          ld_left;
    int          ld_addr;
    bit          ld_done;
    bit          m_pend;
    logic [15:0] m_jmp;
    logic [15:0] m_instr;
    bit          m_pen;
    bit          m_flag;
    int          en_run;
    int          div_val;
    int          flags;
    int          v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        pc          = '0;
        rd          = 1'b0;
        load_start  = 1'b0;
        load_addr   = '0;
        load_len    = '0;
        load_data   = '0;
        load_valid  = 1'b0;
        force_req   = 1'b0;
        force_instr = '0;
        div_en      = 1'b0;
        clkdiv_int  = 16'd1;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a,
                            input logic [15:0] exp);
        rd = 1'b1;
        pc = a;
        tick();
        rd = 1'b0;
        chk(name, instr_data, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1'b1;

        // ---- reset state ----
        repeat (3) tick();
        chk("rst instr_data", instr_data, 0);
        chk("rst load_ready", load_ready, 0);
        chk("rst load_busy", load_busy, 0);
        chk("rst load_done", load_done, 0);
        chk("rst force_pending", force_pending, 0);
        chk("rst flag_abnormal", flag_abnormal, 0);
        chk("rst jmp_data", jmp_data, 0);
        chk("rst penable", penable, 0);
        reset = 1'b0;
        read_chk("fetch pc7 after reset", 5'd7, 16'h0000);

        // ---- wrapping load with a valid gap ----
        load_start = 1'b1;
        load_addr  = 5'd30;
        load_len   = 6'd4;
        tick();
        load_start = 1'b0;
        chk("load ready in LOAD", load_ready, 1);
        chk("load busy in LOAD", load_busy, 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                load_valid = 1'b0;
                tick();
                chk("gap ready held", load_ready, 1);
                chk("gap no done", load_done, 0);
            end
            load_valid = 1'b1;
            load_data  = 16'hA000 + 16'(i);
            tick();
            if (i < 3) chk("no early done", load_done, 0);
        end
        load_valid = 1'b0;
        chk("done after last word", load_done, 1);
        chk("ready low in DONE", load_ready, 0);
        chk("busy in DONE", load_busy, 1);
        tick();
        chk("done one cycle", load_done, 0);
        chk("busy clears", load_busy, 0);

        rv[0] = '{5'd30, 16'hA000};
        rv[1] = '{5'd31, 16'hA001};
        rv[2] = '{5'd0,  16'hA002};
        rv[3] = '{5'd1,  16'hA003};
        rv[4] = '{5'd2,  16'h0000};
        rv[5] = '{5'd29, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            read_chk($sformatf("readback mem[%0d]", rv[i].addr),
                     rv[i].addr, rv[i].exp);
        end

        // ---- illegal lengths are ignored ----
        load_start = 1'b1;
        load_len   = 6'd0;
        load_addr  = 5'd30;
        tick();
        chk("len0 busy", load_busy, 0);
        load_len = 6'd33;
        tick();
        chk("len33 busy", load_busy, 0);
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        tick();
        load_valid = 1'b0;
        chk("len33 ready", load_ready, 0);
        read_chk("mem[30] unchanged", 5'd30, 16'hA000);

        // ---- divider table ----
        dv[0] = '{16'd3, 9};
        dv[1] = '{16'd1, 5};
        dv[2] = '{16'd4, 12};
        dv[3] = '{16'd2, 7};
        for (int k = 0; k < 4; k++) begin
            div_en = 1'b0;
            tick();
            clkdiv_int = dv[k].div;
            div_en     = 1'b1;
            for (int c = 1; c <= dv[k].ncyc; c++) begin
                tick();
                chk($sformatf("div%0d cyc%0d penable", dv[k].div, c),
                    penable, ((c % int'(dv[k].div)) == 0));
            end
            div_en = 1'b0;
            tick();
            chk("penable off after disable", penable, 0);
        end

        // ---- force: latest wins, single strobe ----
        clkdiv_int  = 16'd4;
        div_en      = 1'b1;
        force_req   = 1'b1;
        force_instr = 16'h0025;
        tick();
        chk("force pending set", force_pending, 1);
        chk("jmp first word", jmp_data, 16'h0025);
        force_instr = 16'h0031;
        tick();
        force_req = 1'b0;
        chk("jmp overwritten", jmp_data, 16'h0031);
        flags = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (flag_abnormal) flags++;
            chk("flag only with penable", flag_abnormal & ~penable, 0);
            if (penable && flags == 1 && c < 4) begin
                chk("pending drops on issue", force_pending, 0);
                chk("jmp at issue", jmp_data, 16'h0031);
            end
        end
        chk("single flag_abnormal", flags, 1);
        chk("jmp holds", jmp_data, 16'h0031);

        // ---- pending held while divider is off ----
        div_en      = 1'b0;
        force_req   = 1'b1;
        force_instr = 16'h0077;
        tick();
        force_req = 1'b0;
        repeat (5) tick();
        chk("pending held div off", force_pending, 1);
        chk("no flag div off", flag_abnormal, 0);

        // ---- write-first fetch ----
        load_start = 1'b1;
        load_addr  = 5'd5;
        load_len   = 6'd1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'h1234;
        rd         = 1'b1;
        pc         = 5'd5;
        tick();
        load_valid = 1'b0;
        rd         = 1'b0;
        chk("write-first instr", instr_data, 16'h1234);
        chk("len1 done", load_done, 1);
        tick();

        // ---- reset mid-load ----
        load_start = 1'b1;
        load_addr  = 5'd5;
        load_len   = 6'd3;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'hBEEF;
        tick();
        load_valid = 1'b0;
        chk("busy mid-load", load_busy, 1);
        reset = 1'b1;
        #1;
        chk("async reset busy", load_busy, 0);
        chk("async reset pending", force_pending, 0);
        tick();
        reset = 1'b0;
        read_chk("mem[5] cleared", 5'd5, 16'h0000);
        read_chk("mem[30] cleared", 5'd30, 16'h0000);

        // ---- randomized run against model ----
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mm[i] = '0;
        ld_left = 0;
        ld_addr = 0;
        ld_done = 0;
        m_pend  = 0;
        m_jmp   = '0;
        m_instr = '0;
        en_run  = 0;
        for (int n = 0; n < 3000; n++) begin
            rd          = 1'($urandom_range(0, 1));
            pc          = 5'($urandom);
            load_valid  = ($urandom_range(0, 3) != 0);
            load_data   = 16'($urandom);
            load_start  = ($urandom_range(0, 15) == 0);
            load_addr   = 5'($urandom);
            load_len    = 6'($urandom_range(0, 34));
            force_req   = ($urandom_range(0, 9) == 0);
            force_instr = 16'($urandom);
            if ($urandom_range(0, 39) == 0) div_en = ~div_en;
            if (!div_en && $urandom_range(0, 1) == 1) begin
                v = $urandom_range(0, 7);
                clkdiv_int = (v == 7) ? 16'd0 : 16'(v + 1);
            end

            div_val = (clkdiv_int == 0) ? 65536 : int'(clkdiv_int);
            if (div_en) begin
                en_run++;
                m_pen = ((en_run % div_val) == 0);
            end else begin
                en_run = 0;
                m_pen  = 0;
            end
            m_flag = m_pen && m_pend;
            if (force_req) begin
                m_pend = 1;
                m_jmp  = force_instr;
            end else if (m_pen) begin
                m_pend = 0;
            end

            if (ld_left > 0) begin
                if (load_valid) begin
                    mm[ld_addr] = load_data;
                    ld_addr = (ld_addr + 1) % 32;
                    ld_left--;
                    if (ld_left == 0) ld_done = 1;
                end
            end else if (ld_done) begin
                ld_done = 0;
            end else if (load_start && load_len >= 1 && load_len <= 32) begin
                ld_addr = int'(load_addr);
                ld_left = int'(load_len);
            end
            if (rd) m_instr = mm[pc];

            tick();
            chk("rnd instr_data", instr_data, m_instr);
            chk("rnd load_ready", load_ready, (ld_left > 0));
            chk("rnd load_busy", load_busy, (ld_left > 0) || ld_done);
            chk("rnd load_done", load_done, ld_done);
            chk("rnd penable", penable, m_pen);
            chk("rnd flag_abnormal", flag_abnormal, m_flag);
            chk("rnd force_pending", force_pending, m_pend);
            chk("rnd jmp_data", jmp_data, m_jmp);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
